// File: rtl/tx_pkt_arbiter_pkg.sv
// Shared widths and bus payload for the TX packet arbiter and its neighbours.
package tx_pkt_arbiter_pkg;

    localparam int unsigned TX_DATA_W = 32;
    localparam int unsigned PORT_ID_W = 4;

    typedef struct packed {
        logic [TX_DATA_W-1:0] data;
        logic                 sop;
        logic                 eop;
        logic [PORT_ID_W-1:0] port_id;
    } tx_beat_t;

endpackage

// File: rtl/tx_pkt_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request strictly after i_ptr, with wrap.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int unsigned i = 1; i <= N; i++) begin
            if (!o_valid && i_req[IDX_W'((32'(i_ptr) + i) % N)]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'((32'(i_ptr) + i) % N);
            end
        end
        o_grant = o_valid ? (N'(1) << o_idx) : '0;
    end

endmodule

// File: rtl/tx_pkt_arbiter.sv
// Packet-granular round-robin arbiter sharing the TX internal bus between ports.
module tx_pkt_arbiter
    import tx_pkt_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [NUM_PORTS-1:0]           i_port_en,
    input  logic [NUM_PORTS-1:0]           i_req_valid,
    input  logic [NUM_PORTS*TX_DATA_W-1:0] i_req_data,
    input  logic [NUM_PORTS-1:0]           i_req_sop,
    input  logic [NUM_PORTS-1:0]           i_req_eop,
    output logic [NUM_PORTS-1:0]           o_req_ready,
    output logic                           o_data_en,
    output logic [TX_DATA_W-1:0]           o_data,
    output logic                           o_sop,
    output logic                           o_eop,
    output logic [PORT_ID_W-1:0]           o_port_id,
    output logic                           o_busy,
    output logic                           o_proto_err
);

    localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [IDX_W-1:0]     r_rr;
    logic [IDX_W-1:0]     r_cur;
    logic                 r_gap;
    logic                 w_release;

    logic [NUM_PORTS-1:0] w_cand;
    logic [NUM_PORTS-1:0] w_flush;
    logic [NUM_PORTS-1:0] w_grant;
    logic [IDX_W-1:0]     w_gidx;
    logic                 w_gvalid;
    logic [IDX_W-1:0]     w_sel;
    logic [NUM_PORTS-1:0] w_ready;
    logic                 w_accept;
    logic                 w_err;
    logic                 w_busy_nxt;

    logic [TX_DATA_W-1:0] w_data_arr [NUM_PORTS];
    tx_beat_t             w_beat;
    tx_beat_t             r_beat;
    logic                 r_data_en;
    logic                 r_busy;
    logic                 r_proto_err;

    genvar gp;
    generate
        for (gp = 0; gp < NUM_PORTS; gp++) begin : g_unpack
            assign w_data_arr[gp] = i_req_data[gp*TX_DATA_W +: TX_DATA_W];
        end
    endgenerate

    // r_gap blocks new grants for the one cycle right after a multi-beat packet ends
    assign w_cand  = r_gap ? '0 : (i_req_valid & i_req_sop & i_port_en);
    assign w_flush = i_req_valid & ~i_req_sop & i_port_en;

    rr_arbiter #(
        .N     (NUM_PORTS),
        .IDX_W (IDX_W)
    ) u_rr (
        .i_req   (w_cand),
        .i_ptr   (r_rr),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_valid (w_gvalid)
    );

    assign w_sel = (r_state == ST_LOCK) ? r_cur : w_gidx;

    // Beat as it will appear on the bus; sop is only ever issued on the winning first beat
    always_comb begin
        w_beat.data    = w_data_arr[w_sel];
        w_beat.sop     = (r_state == ST_IDLE);
        w_beat.eop     = i_req_eop[w_sel];
        w_beat.port_id = PORT_ID_W'(w_sel);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = '0;
        w_accept    = 1'b0;
        w_err       = 1'b0;
        w_busy_nxt  = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = w_grant | w_flush;
                w_err   = |w_flush;
                if (w_gvalid) begin
                    w_accept   = 1'b1;
                    w_busy_nxt = !i_req_eop[w_gidx];
                    if (!i_req_eop[w_gidx]) begin
                        w_state_nxt = ST_LOCK;
                    end
                end
            end
            ST_LOCK: begin
                w_ready    = NUM_PORTS'(1) << r_cur;
                w_busy_nxt = 1'b1;
                if (i_req_valid[r_cur]) begin
                    w_accept = 1'b1;
                    w_err    = i_req_sop[r_cur];
                    if (i_req_eop[r_cur]) begin
                        w_state_nxt = ST_IDLE;
                        w_release   = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_req_ready = w_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_rr    <= IDX_W'(NUM_PORTS - 1);
            r_cur   <= '0;
            r_gap   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gap   <= w_release;
            if (r_state == ST_IDLE && w_gvalid) begin
                r_rr  <= w_gidx;
                r_cur <= w_gidx;
            end
        end
    end

    // Bus registers: payload only updates on accepted beats, so it holds across gaps
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data_en   <= 1'b0;
            r_busy      <= 1'b0;
            r_proto_err <= 1'b0;
            r_beat      <= '0;
        end else begin
            r_data_en   <= w_accept;
            r_busy      <= w_busy_nxt;
            r_proto_err <= w_err;
            if (w_accept) begin
                r_beat <= w_beat;
            end
        end
    end

    assign o_data_en   = r_data_en;
    assign o_data      = r_beat.data;
    assign o_sop       = r_beat.sop;
    assign o_eop       = r_beat.eop;
    assign o_port_id   = r_beat.port_id;
    assign o_busy      = r_busy;
    assign o_proto_err = r_proto_err;

endmodule
